// File: rtl/mult_array_stream.sv
// mult_array_stream: streams the outer product of a feature vector and a
// weight vector. It produces one signed product per beat in row-major order
// (j inner, i outer). Each beat carries its indices and row/frame-last flags.
//
// Optional feature: define MULT_ARRAY_STREAM_ACC_EN to build a per-row
// accumulator. On every out_row_last beat, out_acc then holds that row's dot
// product. Without the macro, out_acc is tied to zero.
module mult_array_stream #(
  parameter  int N_FEAT  = 32,
  parameter  int N_WGT   = 34,
  parameter  int DW      = 8,
  parameter  int LATENCY = 2,
  localparam int PW      = 2 * DW,
  localparam int IW      = $clog2(N_FEAT),
  localparam int JW      = $clog2(N_WGT),
  localparam int AW      = PW + JW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_FEAT*DW-1:0] feature,
  input  logic [N_WGT*DW-1:0]  weight,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PW-1:0]        out_product,
  output logic [IW-1:0]        out_i,
  output logic [JW-1:0]        out_j,
  output logic                 out_row_last,
  output logic                 out_last,
  output logic [AW-1:0]        out_acc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  // One pipeline slot: a product plus the sideband that travels with it.
  typedef struct packed {
    logic                 valid;
    logic signed [PW-1:0] prod;
    logic [IW-1:0]        i;
    logic [JW-1:0]        j;
    logic                 row_last;
    logic                 last;
  } beat_t;

  localparam logic [IW-1:0] I_MAX = IW'(N_FEAT - 1);
  localparam logic [JW-1:0] J_MAX = JW'(N_WGT - 1);

  state_t                state_q;
  logic                  in_ready_q;
  logic [IW-1:0]         i_q;
  logic [JW-1:0]         j_q;
  logic [N_FEAT*DW-1:0]  feature_q;
  logic [N_WGT*DW-1:0]   weight_q;
  beat_t                 pipe_q [LATENCY];
  beat_t                 out_q;
  beat_t                 issue_d;

  logic                  pipe_en;
  logic                  last_pair;
  logic                  out_fire;
  logic signed [DW-1:0]  f_sel;
  logic signed [DW-1:0]  w_sel;

  // The whole pipeline advances unless a valid output beat is being refused.
  assign pipe_en   = !(out_q.valid && !out_ready);
  assign last_pair = (i_q == I_MAX) && (j_q == J_MAX);
  assign out_fire  = out_q.valid && out_ready;

  assign f_sel = feature_q[DW*i_q +: DW];
  assign w_sel = weight_q[DW*j_q +: DW];

  // Build the beat for the current (i,j); it is a bubble unless running.
  always_comb begin
    // NOTE: default every field first so no path leaves a latch behind.
    issue_d          = '0;
    issue_d.valid    = (state_q == S_RUN);
    issue_d.prod     = PW'(f_sel) * PW'(w_sel);
    issue_d.i        = i_q;
    issue_d.j        = j_q;
    issue_d.row_last = (j_q == J_MAX);
    issue_d.last     = last_pair;
  end

  // Control FSM with index counters and the registered in_ready.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b1;
      i_q        <= '0;
      j_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            state_q    <= S_RUN;
            in_ready_q <= 1'b0;
            i_q        <= '0;
            j_q        <= '0;
          end
        end
        S_RUN: begin
          if (pipe_en) begin
            if (last_pair) begin
              state_q <= S_DRAIN;
              i_q     <= '0;
              j_q     <= '0;
            end else if (j_q == J_MAX) begin
              j_q <= '0;
              i_q <= i_q + 1'b1;
            end else begin
              j_q <= j_q + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (out_fire && out_q.last) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Capture the operand vectors on acceptance; they are frozen until the next one.
  always_ff @(posedge clk) begin
    // NOTE: operand storage has no reset; it is always written before it is read.
    if (!rst && in_valid && in_ready_q) begin
      feature_q <= feature;
      weight_q  <= weight;
    end
  end

  // Multiplier pipeline and output register; they stall together as one unit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < LATENCY; s++) begin
        pipe_q[s].valid <= 1'b0;
      end
      out_q <= '0;
    end else if (pipe_en) begin
      pipe_q[0] <= issue_d;
      for (int s = 1; s < LATENCY; s++) begin
        pipe_q[s] <= pipe_q[s-1];
      end
      if (pipe_q[LATENCY-1].valid) begin
        out_q <= pipe_q[LATENCY-1];
      end else begin
        out_q.valid <= 1'b0;
      end
    end
  end

`ifdef MULT_ARRAY_STREAM_ACC_EN
  logic signed [AW-1:0] acc_q;
  logic                 row_start_q;

  // Row accumulator. It moves only when a new beat enters the output register,
  // which happens only after the previous beat has been handshaken.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      row_start_q <= 1'b1;
    end else if (pipe_en && pipe_q[LATENCY-1].valid) begin
      acc_q       <= (row_start_q ? '0 : acc_q) + AW'($signed(pipe_q[LATENCY-1].prod));
      row_start_q <= pipe_q[LATENCY-1].row_last;
    end
  end

  assign out_acc = acc_q;
`else
  assign out_acc = '0;
`endif

  assign in_ready     = in_ready_q;
  assign out_valid    = out_q.valid;
  assign out_product  = out_q.prod;
  assign out_i        = out_q.i;
  assign out_j        = out_q.j;
  assign out_row_last = out_q.row_last;
  assign out_last     = out_q.last;

endmodule

// File: tb/tb_mult_array_stream.sv
// Directed bench for mult_array_stream: a default-size instance and a small
// 3x5 instance with LATENCY=1. Expected values come from the operand tables
// kept in the bench. out_acc expectations follow MULT_ARRAY_STREAM_ACC_EN.
module tb_mult_array_stream;

  localparam int NF  = 32;
  localparam int NW  = 34;
  localparam int DW  = 8;
  localparam int PW  = 16;
  localparam int IW  = 5;
  localparam int JW  = 6;
  localparam int AW  = 22;
  localparam int NB  = NF * NW;

  localparam int SNF = 3;
  localparam int SNW = 5;
  localparam int SIW = 2;
  localparam int SJW = 3;
  localparam int SAW = 19;
  localparam int SNB = SNF * SNW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // default-size instance
  logic                 in_valid, in_ready, out_valid, out_ready, out_row_last, out_last;
  logic [NF*DW-1:0]     feature;
  logic [NW*DW-1:0]     weight;
  logic [PW-1:0]        out_product;
  logic [IW-1:0]        out_i;
  logic [JW-1:0]        out_j;
  logic [AW-1:0]        out_acc;

  // small instance
  logic                 s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_row_last, s_out_last;
  logic [SNF*DW-1:0]    s_feature;
  logic [SNW*DW-1:0]    s_weight;
  logic [PW-1:0]        s_out_product;
  logic [SIW-1:0]       s_out_i;
  logic [SJW-1:0]       s_out_j;
  logic [SAW-1:0]       s_out_acc;

  mult_array_stream u_dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .feature      (feature),
    .weight       (weight),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_product  (out_product),
    .out_i        (out_i),
    .out_j        (out_j),
    .out_row_last (out_row_last),
    .out_last     (out_last),
    .out_acc      (out_acc)
  );

  mult_array_stream #(.N_FEAT(SNF), .N_WGT(SNW), .DW(DW), .LATENCY(1)) u_small (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (s_in_valid),
    .in_ready     (s_in_ready),
    .feature      (s_feature),
    .weight       (s_weight),
    .out_valid    (s_out_valid),
    .out_ready    (s_out_ready),
    .out_product  (s_out_product),
    .out_i        (s_out_i),
    .out_j        (s_out_j),
    .out_row_last (s_out_row_last),
    .out_last     (s_out_last),
    .out_acc      (s_out_acc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int fv [NF];
  int wv [NW];
  int sfv [SNF];
  int swv [SNW];
  logic [PW-1:0] prod_log   [NB];
  logic [PW-1:0] s_prod_log [SNB];
  logic [AW-1:0] last_acc;
  int            first_lat;
  int            got;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int row_sum(input int i);
    int s = 0;
    for (int j = 0; j < NW; j++) s += fv[i] * wv[j];
    return s;
  endfunction

  function automatic int s_row_sum(input int i);
    int s = 0;
    for (int j = 0; j < SNW; j++) s += sfv[i] * swv[j];
    return s;
  endfunction

  // Present the operand tables and perform the acceptance handshake.
  task automatic start_u0();
    for (int k = 0; k < NF; k++) feature[k*DW +: DW] = fv[k][DW-1:0];
    for (int k = 0; k < NW; k++) weight[k*DW +: DW]  = wv[k][DW-1:0];
    @(negedge clk);
    check("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Consume beats and compare each one with the operand tables.
  task automatic collect_u0(input int stop_at, input bit stall, input bit junk,
                            output int lat, output int beats);
    int beat = 0;
    int cyc  = 0;
    bit held_v = 1'b0;
    logic [63:0] held = '0;
    logic [63:0] cur;
    logic [PW-1:0] ep;
    logic [AW-1:0] ea;
    int ei, ej, p, rs;
    lat = -1;
    while (beat < stop_at && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (junk && cyc == 1) begin
        for (int k = 0; k < NF; k++) feature[k*DW +: DW] = 8'($urandom);
        for (int k = 0; k < NW; k++) weight[k*DW +: DW]  = 8'($urandom);
      end
      in_valid  = junk && (beat < 1000);
      out_ready = stall ? ((cyc % 4 == 1) || (cyc % 4 == 0)) : 1'b1;
      cur = {out_product, out_i, out_j, out_row_last, out_last, out_acc};
      if (held_v) check("stall_stable", {out_valid, cur}, {1'b1, held});
      held_v = out_valid && !out_ready;
      held   = cur;
      if (out_valid && lat < 0) lat = cyc;
      if (out_valid && out_ready) begin
        ei = beat / NW;
        ej = beat % NW;
        p  = fv[ei] * wv[ej];
        ep = p[PW-1:0];
        check("beat", {out_product, out_i, out_j, out_row_last, out_last},
              {ep, IW'(ei), JW'(ej), (ej == NW-1), (beat == NB-1)});
`ifdef MULT_ARRAY_STREAM_ACC_EN
        if (ej == NW-1) begin
          rs = row_sum(ei);
          ea = rs[AW-1:0];
          check("row_acc", out_acc, ea);
        end
`else
        check("acc_tied_zero", out_acc, 0);
`endif
        prod_log[beat] = out_product;
        if (beat == NB-1) last_acc = out_acc;
        beat++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (beat < stop_at) check("beats_timeout", beat, stop_at);
    beats = beat;
  endtask

  task automatic finish_u0();
    @(negedge clk);
    check("idle_after_last", {in_ready, out_valid}, 2'b10);
  endtask

  task automatic run_small(output int lat);
    int beat = 0;
    int cyc  = 0;
    int ei, ej, p, rs;
    logic [PW-1:0]  ep;
    logic [SAW-1:0] ea;
    lat = -1;
    for (int k = 0; k < SNF; k++) s_feature[k*DW +: DW] = sfv[k][DW-1:0];
    for (int k = 0; k < SNW; k++) s_weight[k*DW +: DW]  = swv[k][DW-1:0];
    @(negedge clk);
    check("s_in_ready_before_accept", s_in_ready, 1);
    s_in_valid = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0;
    while (beat < SNB && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (s_out_valid && lat < 0) lat = cyc;
      if (s_out_valid) begin
        ei = beat / SNW;
        ej = beat % SNW;
        p  = sfv[ei] * swv[ej];
        ep = p[PW-1:0];
        check("s_beat", {s_out_product, s_out_i, s_out_j, s_out_row_last, s_out_last},
              {ep, SIW'(ei), SJW'(ej), (ej == SNW-1), (beat == SNB-1)});
`ifdef MULT_ARRAY_STREAM_ACC_EN
        if (ej == SNW-1) begin
          rs = s_row_sum(ei);
          ea = rs[SAW-1:0];
          check("s_row_acc", s_out_acc, ea);
        end
`else
        check("s_acc_tied_zero", s_out_acc, 0);
`endif
        s_prod_log[beat] = s_out_product;
        beat++;
      end
    end
    if (beat < SNB) check("s_beats_timeout", beat, SNB);
    @(negedge clk);
    check("s_idle_after_last", {s_in_ready, s_out_valid}, 2'b10);
  endtask

  initial begin
    bit seen;
    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    feature     = '0;
    weight      = '0;
    s_in_valid  = 1'b0;
    s_out_ready = 1'b1;
    s_feature   = '0;
    s_weight    = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_outputs", {out_valid, out_product, out_i, out_j, out_row_last, out_last, out_acc}, 0);
    check("rst_s_in_ready", s_in_ready, 1);
    check("rst_s_outputs", {s_out_valid, s_out_product, s_out_i, s_out_j, s_out_row_last, s_out_last, s_out_acc}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Ramp features against a constant weight.
    for (int k = 0; k < NF; k++) fv[k] = k + 1;
    for (int k = 0; k < NW; k++) wv[k] = 2;
    start_u0();
    collect_u0(NB, 1'b0, 1'b0, first_lat, got);
    check("first_valid_latency", first_lat, 3);
    check("beat_5_7_product", prod_log[5*NW+7], 16'd12);
    finish_u0();

    // Most-negative operand corners.
    for (int k = 0; k < NF; k++) fv[k] = k - 16;
    for (int k = 0; k < NW; k++) wv[k] = 17 - k;
    fv[0] = -128;
    fv[1] = 127;
    wv[0] = -128;
    start_u0();
    collect_u0(NB, 1'b0, 1'b0, first_lat, got);
    check("neg_by_neg", prod_log[0], 16'h4000);
    check("pos_by_neg", prod_log[NW], 16'hC080);
    finish_u0();

    // Random operands with a 1-0-0-1 out_ready pattern. The input vectors change
    // and in_valid stays high after acceptance; both must be ignored.
    for (int k = 0; k < NF; k++) fv[k] = int'($urandom_range(0, 255)) - 128;
    for (int k = 0; k < NW; k++) wv[k] = int'($urandom_range(0, 255)) - 128;
    start_u0();
    collect_u0(NB, 1'b1, 1'b1, first_lat, got);
    check("stall_first_valid_latency", first_lat, 3);
    finish_u0();

    // Reset mid-frame, with in_valid asserted alongside rst.
    start_u0();
    collect_u0(500, 1'b0, 1'b0, first_lat, got);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("after_rst_ready_valid", {in_ready, out_valid}, 2'b10);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | out_valid | ~in_ready;
    end
    check("quiet_after_rst", seen, 0);
    start_u0();
    collect_u0(NB, 1'b0, 1'b0, first_lat, got);
    check("post_rst_first_valid_latency", first_lat, 3);
    finish_u0();

    // Uniform operands: every row sums to 34 * (3 * -1) = -102.
    for (int k = 0; k < NF; k++) fv[k] = 3;
    for (int k = 0; k < NW; k++) wv[k] = -1;
    start_u0();
    collect_u0(NB, 1'b0, 1'b0, first_lat, got);
`ifdef MULT_ARRAY_STREAM_ACC_EN
    check("last_row_acc", last_acc, 22'h3FFF9A);
`else
    check("last_row_acc", last_acc, 0);
`endif
    finish_u0();

    // Small non-power-of-two instance, LATENCY=1.
    sfv[0] = 1;  sfv[1] = -2; sfv[2] = 3;
    swv[0] = 1;  swv[1] = 2;  swv[2] = 3; swv[3] = 4; swv[4] = -5;
    run_small(first_lat);
    check("s_first_valid_latency", first_lat, 2);
    check("s_wrap_beat_product", s_prod_log[5], 16'hFFFE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
